reduce_tx: RTL and testbench

// - Transmit side of the inter-MVM reduction link. Takes OPREC-wide partial-sum vectors

---
 rtl/reduce_pkg.sv | 47 ++++
 rtl/reduce_tx_if.sv | 29 ++
 rtl/reduce_tx_fifo.sv | 57 +++++
 rtl/reduce_tx.sv | 132 +++++++++++++
 tb/tb_reduce_tx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/reduce_pkg.sv
// Shared definitions for the reduction transmit link: FSM encoding, saturation
// bounds and the requantization math also used by the peer's expected-value model.
package reduce_pkg;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  function automatic longint sat_max(input int iprec);
    return (longint'(1) <<< (iprec - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int iprec);
    return -(longint'(1) <<< (iprec - 1));
  endfunction

  // 64-bit arithmetic leaves headroom so the rounding offset can never overflow
  function automatic longint requant_shift(input longint x, input int shift, input bit round);
    longint xr;
    xr = x;
    if (round && shift > 0) begin
      xr = x + (longint'(1) <<< (shift - 1));
    end
    return xr >>> shift;
  endfunction

  function automatic bit requant_sat(input longint x, input int shift, input int iprec,
                                     input bit round);
    longint y;
    y = requant_shift(x, shift, round);
    return (y > sat_max(iprec)) || (y < sat_min(iprec));
  endfunction

  function automatic longint requant(input longint x, input int shift, input int iprec,
                                     input bit round);
    longint y;
    y = requant_shift(x, shift, round);
    if (y > sat_max(iprec)) begin
      y = sat_max(iprec);
    end else if (y < sat_min(iprec)) begin
      y = sat_min(iprec);
    end
    return y;
  endfunction

endpackage

// File: rtl/reduce_tx_if.sv
// Host-side input and peer-side transmit signals of the reduction link.
// The slave modport is the reduce_tx view; master is the host/peer view.
interface reduce_tx_if #(
  parameter int IPREC = 8,
  parameter int OPREC = 32
);
  logic             i_valid;
  logic [OPREC-1:0] i_data;
  logic             i_last;
  logic             i_enable;
  logic             o_ready;
  logic             o_tx_valid;
  logic [IPREC-1:0] o_tx_data;
  logic             o_tx_last;
  logic             i_tx_ready;
  logic             o_sat;
  logic             o_len_err;
  logic             o_busy;

  modport slave (
    input  i_valid, i_data, i_last, i_enable, i_tx_ready,
    output o_ready, o_tx_valid, o_tx_data, o_tx_last, o_sat, o_len_err, o_busy
  );

  modport master (
    output i_valid, i_data, i_last, i_enable, i_tx_ready,
    input  o_ready, o_tx_valid, o_tx_data, o_tx_last, o_sat, o_len_err, o_busy
  );
endinterface

// File: rtl/reduce_tx_fifo.sv
// Show-ahead synchronous FIFO holding {last,data} transmit entries.
module reduce_tx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reduce_tx.sv
// Transmit side of the inter-MVM reduction link: requantize, buffer, stream to peer.
// Build option: define REDUCE_TX_ROUND_EN for round-half-up instead of truncation.
module reduce_tx
  import reduce_pkg::*;
#(
  parameter int IPREC = 8,
  parameter int OPREC = 32,
  parameter int SHIFT = 8,
  parameter int DEPTH = 8,
  parameter int VLEN  = 64
) (
  input  logic        clk,
  input  logic        rst,
  reduce_tx_if.slave  bus
);
  localparam int CNT_W  = $clog2(VLEN);
  localparam int FCNT_W = $clog2(DEPTH) + 1;
`ifdef REDUCE_TX_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   elem_cnt;
  logic               fwd_q;
  logic               fwd_now;
  logic               stage_valid;
  logic               stage_last;
  logic [IPREC-1:0]   stage_data;
  logic               sat_q;
  logic               len_err_q;
  logic               ready;
  logic               accept;
  logic               cnt_max;
  logic               beat_last;
  logic               overrun;
  logic [FCNT_W:0]    occupancy;
  longint             x_ext;
  logic [IPREC-1:0]   rq_data;
  logic               rq_sat;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [FCNT_W-1:0]  fifo_count;
  logic [IPREC:0]     fifo_rdata;

  // Readiness looks only at registered occupancy so it never depends on i_tx_ready
  assign occupancy = {1'b0, fifo_count} + (FCNT_W + 1)'(stage_valid);
  assign ready     = !fifo_full && (occupancy < (FCNT_W + 1)'(DEPTH));
  assign accept    = bus.i_valid && ready;
  assign cnt_max   = (elem_cnt == CNT_W'(VLEN - 1));
  assign beat_last = bus.i_last || cnt_max;
  assign overrun   = accept && cnt_max && !bus.i_last;
  assign fwd_now   = (state_q == S_IDLE) ? bus.i_enable : fwd_q;

  assign x_ext   = longint'({{(64 - OPREC){bus.i_data[OPREC-1]}}, bus.i_data});
  assign rq_data = IPREC'(requant(x_ext, SHIFT, IPREC, ROUND));
  assign rq_sat  = requant_sat(x_ext, SHIFT, IPREC, ROUND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A vector spans IDLE->ACTIVE->IDLE; single-beat vectors never leave IDLE
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        S_IDLE:   if (!beat_last) state_d = S_ACTIVE;
        S_ACTIVE: if (beat_last)  state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Per-vector bookkeeping and the single requant register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_cnt    <= '0;
      fwd_q       <= 1'b0;
      stage_valid <= 1'b0;
      stage_last  <= 1'b0;
      stage_data  <= '0;
      sat_q       <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      stage_valid <= accept && fwd_now;
      sat_q       <= accept && rq_sat;
      len_err_q   <= len_err_q || overrun;
      if (accept) begin
        elem_cnt   <= beat_last ? '0 : elem_cnt + CNT_W'(1);
        stage_data <= rq_data;
        stage_last <= beat_last;
        if (state_q == S_IDLE) begin
          fwd_q <= bus.i_enable;
        end
      end
    end
  end

  assign fifo_pop = !fifo_empty && bus.i_tx_ready;

  reduce_tx_fifo #(
    .WIDTH (IPREC + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stage_valid),
    .wdata ({stage_last, stage_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.o_ready    = ready;
  assign bus.o_tx_valid = !fifo_empty;
  assign bus.o_tx_data  = fifo_empty ? '0 : fifo_rdata[IPREC-1:0];
  assign bus.o_tx_last  = !fifo_empty && fifo_rdata[IPREC];
  assign bus.o_sat      = sat_q;
  assign bus.o_len_err  = len_err_q;
  assign bus.o_busy     = (state_q == S_ACTIVE) || stage_valid || !fifo_empty;

endmodule

// File: tb/tb_reduce_tx.sv
// Directed bench for reduce_tx: table of single-beat requant vectors plus
// hand-written backpressure, disabled-vector, length-overrun and reset sequences.
module tb_reduce_tx;
`ifdef REDUCE_TX_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [7:0]  exp_trunc;
    logic [7:0]  exp_round;
    logic        sat_trunc;
    logic        sat_round;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  reduce_tx_if #(.IPREC(8), .OPREC(32)) bus ();

  reduce_tx #(
    .IPREC (8),
    .OPREC (32),
    .SHIFT (8),
    .DEPTH (8),
    .VLEN  (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic last,
                               input logic enable);
    bus.i_valid  = valid;
    bus.i_data   = data;
    bus.i_last   = last;
    bus.i_enable = enable;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  vec_t vecs[10];

  initial begin
    int idx;
    int rx;
    int cyc;
    logic saw_valid;
    logic [7:0] held;

    vecs[0] = '{32'h0000_0380, 8'h03, 8'h04, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 8'h7F, 8'h7F, 1'b1, 1'b1};
    vecs[2] = '{32'h8000_0000, 8'h80, 8'h80, 1'b1, 1'b1};
    vecs[3] = '{32'h0000_7F00, 8'h7F, 8'h7F, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_8000, 8'h7F, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{32'hFFFF_FF80, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_8000, 8'h80, 8'h80, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_7FFF, 8'h80, 8'h80, 1'b1, 1'b0};
    vecs[8] = '{32'h0000_0000, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{32'h0000_12FF, 8'h12, 8'h13, 1'b0, 1'b0};

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    bus.i_tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_tx_valid", 64'(bus.o_tx_valid), 64'd0);
    checkOutput("rst_ready",    64'(bus.o_ready),    64'd1);
    checkOutput("rst_len_err",  64'(bus.o_len_err),  64'd0);
    checkOutput("rst_busy",     64'(bus.o_busy),     64'd0);
    checkOutput("rst_sat",      64'(bus.o_sat),      64'd0);

    // Single-beat vectors: sat at N+1, data at N+2, FIFO drained at N+3
    bus.i_tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].data, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("vec_sat",     64'(bus.o_sat), 64'(ROUND ? vecs[i].sat_round : vecs[i].sat_trunc));
      checkOutput("vec_early",   64'(bus.o_tx_valid), 64'd0);
      @(negedge clk);
      checkOutput("vec_valid",   64'(bus.o_tx_valid), 64'd1);
      checkOutput("vec_data",    64'(bus.o_tx_data), 64'(ROUND ? vecs[i].exp_round : vecs[i].exp_trunc));
      checkOutput("vec_last",    64'(bus.o_tx_last), 64'd1);
      checkOutput("vec_sat_end", 64'(bus.o_sat), 64'd0);
      @(negedge clk);
      checkOutput("vec_drained", 64'(bus.o_tx_valid), 64'd0);
    end

    // Backpressure: 10-beat vector into an 8-deep pipe with the peer stalled
    bus.i_tx_ready = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 10 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus.o_ready) begin
        applyStimulus(1'b1, 32'((idx + 1) << 8), idx == 9, 1'b1);
        idx++;
      end else begin
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        break;
      end
    end
    checkOutput("bp_accepted", 64'(idx), 64'd8);
    held = bus.o_tx_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", 64'(bus.o_tx_valid), 64'd1);
      checkOutput("bp_hold",  64'(bus.o_tx_data),  64'(held));
      checkOutput("bp_ready", 64'(bus.o_ready),    64'd0);
    end
    checkOutput("bp_first", 64'(held), 64'h01);
    rx = 0;
    cyc = 0;
    while (rx < 10 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      bus.i_tx_ready = 1'b1;
      if (bus.o_tx_valid) begin
        checkOutput("bp_data", 64'(bus.o_tx_data), 64'(rx + 1));
        checkOutput("bp_last", 64'(bus.o_tx_last), 64'(rx == 9));
        rx++;
      end
      if (idx < 10 && bus.o_ready) begin
        applyStimulus(1'b1, 32'((idx + 1) << 8), idx == 9, 1'b1);
        idx++;
      end else begin
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      end
    end
    checkOutput("bp_rx_count", 64'(rx), 64'd10);

    // Vector with i_enable=0 on its first beat is consumed but never sent
    @(negedge clk);
    saw_valid = 1'b0;
    applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | bus.o_tx_valid;
      if (i == 1) begin
        checkOutput("dis_sat",  64'(bus.o_sat),  64'd1);
        checkOutput("dis_busy", 64'(bus.o_busy), 64'd1);
      end
      applyStimulus(1'b1, 32'h0000_0200, i == 3, 1'b1);
    end
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      saw_valid = saw_valid | bus.o_tx_valid;
      @(negedge clk);
    end
    checkOutput("dis_no_tx", 64'(saw_valid), 64'd0);
    checkOutput("dis_idle",  64'(bus.o_busy), 64'd0);
    applyStimulus(1'b1, 32'h0000_0500, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("dis_next_valid", 64'(bus.o_tx_valid), 64'd1);
    checkOutput("dis_next_data",  64'(bus.o_tx_data),  64'h05);
    @(negedge clk);

    // 65 beats without i_last: beat 64 closes the vector, beat 65 opens a new one
    checkOutput("ovr_len_err_pre", 64'(bus.o_len_err), 64'd0);
    idx = 0;
    rx = 0;
    cyc = 0;
    while (rx < 65 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.o_tx_valid) begin
        checkOutput("ovr_data", 64'(bus.o_tx_data), 64'(rx));
        checkOutput("ovr_last", 64'(bus.o_tx_last), 64'(rx == 63));
        rx++;
      end
      if (idx < 65 && bus.o_ready) begin
        applyStimulus(1'b1, 32'(idx << 8), 1'b0, 1'b1);
        idx++;
      end else begin
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      end
    end
    checkOutput("ovr_rx_count", 64'(rx), 64'd65);
    checkOutput("ovr_len_err",  64'(bus.o_len_err), 64'd1);
    checkOutput("ovr_new_vec",  64'(bus.o_busy), 64'd1);

    // Reset mid-stream with data queued
    bus.i_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1);
      @(negedge clk);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("mid_queued", 64'(bus.o_tx_valid), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid",   64'(bus.o_tx_valid), 64'd0);
    checkOutput("mid_rst_busy",    64'(bus.o_busy),     64'd0);
    checkOutput("mid_rst_len_err", 64'(bus.o_len_err),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 64'(bus.o_ready),    64'd1);
    checkOutput("post_rst_valid", 64'(bus.o_tx_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
